hls_sobel_axi_stream_top_hls_deadlock_reporter: RTL
===================================================

HLS_SOBEL_AXI_STREAM_TOP_HLS_DEADLOCK_REPORTER -- requirements
Module: hls_sobel_axi_stream_top_hls_deadlock_reporter

Interface
REQ-001 Parameter THRESHOLD, default 16, SHALL set the consecutive block cycles needed to declare deadlock; legal range 1..65535.
REQ-002 Parameter TS_WIDTH, default 32, SHALL set the timestamp counter width; fixed at 32 for the report format.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 block  input  1  top-level deadlock-monitor output: all processes stopped with an AXIS block present.
REQ-006 inst_block_sigs  input  7  per-process channel-block flags.
REQ-007 inst_idle_sigs  input  7  per-process idle flags.
REQ-008 axis_block_sigs  input  4  per-AXIS-port block flags.
REQ-009 clear  input  1  acknowledges a latched deadlock and re-arms detection.
REQ-010 deadlock  output  1  sticky flag; high from declaration until cleared.
REQ-011 rpt_data  output  32  report word.
REQ-012 rpt_valid  output  1  report word valid.
REQ-013 rpt_ready  input  1  consumer accepts report word.
REQ-014 rpt_last  output  1  marks the final report word.

Function
REQ-015 The free-running 32-bit timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-016 States: IDLE, WATCH, REPORT, LATCHED.
REQ-017 IDLE: block=1 -> WATCH; persist counter := 1; capture the current timestamp as t_first.
REQ-018 WATCH: each cycle with block=1 SHALL increment persist; block=0 -> IDLE with persist := 0.
REQ-019 Deadlock SHALL be declared in the cycle in which block is sampled high with persist already equal to THRESHOLD-1; for THRESHOLD=1 declaration occurs on the IDLE->WATCH sample and the FSM goes directly IDLE->REPORT.
REQ-020 On declaration: snapshot inst_block_sigs, inst_idle_sigs and axis_block_sigs as sampled in that cycle; deadlock := 1 next cycle; FSM -> REPORT.
REQ-021 REPORT SHALL emit 3 words in order: W0 = {8'hD1, 8'h01, THRESHOLD[15:0]}; W1 = {14'b0, axis[3:0], idle[6:0], blk[6:0]}; W2 = t_first.
REQ-022 rpt_valid SHALL stay high, and rpt_data SHALL stay stable, until rpt_ready=1; a word advances only on valid&ready.
REQ-023 rpt_last SHALL be high only with W2; the W2 handshake -> LATCHED with rpt_valid := 0 next cycle.
REQ-024 In REPORT, block and clear SHALL be ignored; the report always completes.
REQ-025 In LATCHED, block SHALL be ignored; clear=1 -> IDLE with deadlock := 0 and persist := 0 next cycle.
REQ-026 A block sample in the same cycle as a LATCHED clear SHALL NOT start WATCH; detection restarts from the following cycle.
REQ-027 clear in IDLE or WATCH SHALL have no effect.

Reset
REQ-028 While reset=1: FSM=IDLE, deadlock=0, rpt_valid=0, rpt_last=0, rpt_data=0, persist=0, timestamp=0, snapshots=0.
REQ-029 Reset asserted mid-REPORT SHALL drop rpt_valid immediately (asynchronously) without completing the report.

Structure
REQ-030 Package hls_sobel_axi_stream_top_hls_deadlock_pkg SHALL hold the state enum, the magic value 8'hD1, the version value 8'h01, the word count 3 and the W1 field offsets.
REQ-031 Sub-module hls_sobel_axi_stream_top_hls_deadlock_report_ser SHALL implement the 3-word valid/ready serializer; the FSM, persist counter and timestamp stay in the top.

Verification
REQ-032 Block high 16 cycles starting at timestamp 100, rpt_ready=1 -> deadlock rises after the 16th sample; words D101_0010, snapshot word, 0x00000064; rpt_last on word 3.
REQ-033 Block high 15 cycles, low 1 cycle, then high 16 cycles -> no declaration on the first burst; t_first equals the start of the second burst.
REQ-034 rpt_ready held low 5 cycles on each word -> rpt_data is stable and rpt_valid is held; all 3 words arrive exactly once.
REQ-035 In LATCHED, clear and block asserted in the same cycle, then block held 16 more cycles -> deadlock drops, then is re-declared 16 cycles after the cycle following clear.
REQ-036 Reset pulsed during W1 -> rpt_valid=0 and deadlock=0 at once; no W2 is emitted; a later deadlock reports normally.
REQ-037 THRESHOLD=1, single-cycle block pulse with inst_block=7'h55 and axis=4'h8 -> immediate REPORT; W1 = 0x000200xx with blk=0x55 and idle per stimulus.

Source files
------------

// File: rtl/hls_sobel_axi_stream_top_hls_deadlock_pkg.sv
// Shared types and report-format constants for the HLS deadlock reporter.
package hls_sobel_axi_stream_top_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } dl_state_e;

  localparam logic [7:0] RPT_MAGIC   = 8'hD1;
  localparam logic [7:0] RPT_VERSION = 8'h01;
  localparam int         RPT_WORDS   = 3;
  localparam int         RPT_W       = 32;

  localparam int NUM_INST = 7;
  localparam int NUM_AXIS = 4;

  localparam int W1_BLK_LSB  = 0;
  localparam int W1_IDLE_LSB = 7;
  localparam int W1_AXIS_LSB = 14;

  typedef struct packed {
    logic [NUM_AXIS-1:0] axis;
    logic [NUM_INST-1:0] idle;
    logic [NUM_INST-1:0] blk;
  } snap_t;

  function automatic logic [RPT_W-1:0] pack_w0(input logic [15:0] thr);
    return {RPT_MAGIC, RPT_VERSION, thr};
  endfunction

  function automatic logic [RPT_W-1:0] pack_w1(input snap_t s);
    logic [RPT_W-1:0] w;
    w = '0;
    w[W1_BLK_LSB  +: NUM_INST] = s.blk;
    w[W1_IDLE_LSB +: NUM_INST] = s.idle;
    w[W1_AXIS_LSB +: NUM_AXIS] = s.axis;
    return w;
  endfunction

endpackage

// File: rtl/hls_sobel_axi_stream_top_hls_deadlock_report_ser.sv
// Valid/ready serializer: loads a word array on start, emits it in order, flags the last word.
module hls_sobel_axi_stream_top_hls_deadlock_report_ser
  import hls_sobel_axi_stream_top_hls_deadlock_pkg::*;
#(
  parameter int NUM_WORDS = RPT_WORDS,
  parameter int WORD_W    = RPT_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_WORDS-1:0][WORD_W-1:0] words,
  input  logic                             rpt_ready,
  output logic [WORD_W-1:0]                rpt_data,
  output logic                             rpt_valid,
  output logic                             rpt_last,
  output logic                             done
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  logic [NUM_WORDS-1:0][WORD_W-1:0] words_q;
  logic [IDX_W-1:0]                 idx_q;
  logic                             valid_q;
  logic                             fire;
  logic                             at_last;

  assign fire    = valid_q & rpt_ready;
  assign at_last = (idx_q == IDX_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (start && !valid_q) begin
      words_q <= words;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      if (at_last) valid_q <= 1'b0;
      else         idx_q   <= idx_q + 1'b1;
    end
  end

  // Data is gated so the bus reads zero whenever no word is on offer.
  assign rpt_data  = valid_q ? words_q[idx_q] : '0;
  assign rpt_valid = valid_q;
  assign rpt_last  = valid_q & at_last;
  assign done      = fire & at_last;

endmodule

// File: rtl/hls_sobel_axi_stream_top_hls_deadlock_reporter.sv
// Watches the HLS deadlock-monitor block flag, declares deadlock after THRESHOLD
// consecutive cycles, then emits a 3-word snapshot report and latches until cleared.
module hls_sobel_axi_stream_top_hls_deadlock_reporter
  import hls_sobel_axi_stream_top_hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = 16,
  parameter int TS_WIDTH  = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                deadlock,
  output logic [RPT_W-1:0]    rpt_data,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic                rpt_last
);

  localparam logic [15:0] PERSIST_LAST = 16'(THRESHOLD - 1);
  localparam logic [15:0] THR16        = 16'(THRESHOLD);

  dl_state_e           state_q, state_d;
  logic [15:0]         persist_q, persist_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] t_first_q, t_first_d;
  logic                deadlock_q, deadlock_d;
  logic                declare;
  logic                rpt_done;
  snap_t               snap;

  logic [RPT_WORDS-1:0][RPT_W-1:0] words;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      persist_q  <= '0;
      t_first_q  <= '0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      persist_q  <= persist_d;
      t_first_q  <= t_first_d;
      deadlock_q <= deadlock_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    persist_d  = persist_q;
    t_first_d  = t_first_q;
    deadlock_d = deadlock_q;
    declare    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (block) begin
          t_first_d = ts_q;
          persist_d = 16'd1;
          // A threshold of one means the very first sample is the declaring one.
          if (THRESHOLD == 1) begin
            declare    = 1'b1;
            deadlock_d = 1'b1;
            state_d    = ST_REPORT;
          end else begin
            state_d = ST_WATCH;
          end
        end
      end
      ST_WATCH: begin
        if (!block) begin
          state_d   = ST_IDLE;
          persist_d = '0;
        end else if (persist_q == PERSIST_LAST) begin
          declare    = 1'b1;
          deadlock_d = 1'b1;
          state_d    = ST_REPORT;
        end else begin
          persist_d = persist_q + 16'd1;
        end
      end
      ST_REPORT: begin
        if (rpt_done) state_d = ST_LATCHED;
      end
      ST_LATCHED: begin
        if (clear) begin
          state_d    = ST_IDLE;
          deadlock_d = 1'b0;
          persist_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The serializer registers these on declare, which is the snapshot point.
  assign snap.axis = axis_block_sigs;
  assign snap.idle = inst_idle_sigs;
  assign snap.blk  = inst_block_sigs;

  assign words[0] = pack_w0(THR16);
  assign words[1] = pack_w1(snap);
  assign words[2] = RPT_W'(t_first_d);

  hls_sobel_axi_stream_top_hls_deadlock_report_ser #(
    .NUM_WORDS (RPT_WORDS),
    .WORD_W    (RPT_W)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .start     (declare),
    .words     (words),
    .rpt_ready (rpt_ready),
    .rpt_data  (rpt_data),
    .rpt_valid (rpt_valid),
    .rpt_last  (rpt_last),
    .done      (rpt_done)
  );

  assign deadlock = deadlock_q;

endmodule
